// File: rtl/ifu_fetch_redirect_ysyx23060136_pkg.sv
// Shared types and constants for the IF-stage fetch/redirect block.
package ifu_pkg_ysyx23060136;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} ifu_state_t;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/ifu_fetch_redirect_ysyx23060136_if.sv
// Fetch bus: AR/R channel to instruction memory plus the valid/ready hand-off to ID.
interface ifu_fetch_redirect_ysyx23060136_if;
  logic [31:0] IFU_araddr;
  logic        IFU_arvalid;
  logic        IFU_arready;
  logic [31:0] IFU_rdata;
  logic [1:0]  IFU_rresp;
  logic        IFU_rvalid;
  logic        IFU_rready;
  logic        IFU_valid;
  logic        IFU_ready;
  logic [31:0] IFU_pc;
  logic [31:0] IFU_inst;
  logic        IFU_fault;

  modport master (
    output IFU_araddr, IFU_arvalid, IFU_rready, IFU_valid, IFU_pc, IFU_inst, IFU_fault,
    input  IFU_arready, IFU_rdata, IFU_rresp, IFU_rvalid, IFU_ready
  );
  modport slave (
    input  IFU_araddr, IFU_arvalid, IFU_rready, IFU_valid, IFU_pc, IFU_inst, IFU_fault,
    output IFU_arready, IFU_rdata, IFU_rresp, IFU_rvalid, IFU_ready
  );
endinterface

// File: rtl/ifu_fetch_redirect_ysyx23060136_pc_reg.sv
// Architectural PC register; redirect target beats the sequential +4 step.
module ifu_pc_reg_ysyx23060136
  import ifu_pkg_ysyx23060136::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [ILEN-1:0] target,
  input  logic            advance,
  output logic [ILEN-1:0] pc_q,
  output logic [ILEN-1:0] pc_d
);
  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = target;
    else if (advance) pc_d = pc_q + ILEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end
endmodule

// File: rtl/ifu_fetch_redirect_ysyx23060136.sv
// IF-stage fetch master: issues one read at a time, hands instructions to ID,
// and squashes wrong-path fetches (including an in-flight response) on redirect.
module ifu_fetch_redirect_ysyx23060136
  import ifu_pkg_ysyx23060136::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ILEN     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  BRANCH_PCSrc,
  input  logic [ILEN-1:0]                       BRANCH_target,
  ifu_fetch_redirect_ysyx23060136_if.master     bus
);
  ifu_state_t      state_q, state_d;
  logic            kill_q, kill_d;
  logic [ILEN-1:0] req_addr_q, req_addr_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [ILEN-1:0] pc_q, pc_d;
  logic            advance;

  ifu_pc_reg_ysyx23060136 #(.RESET_PC(RESET_PC), .ILEN(ILEN)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .redirect (BRANCH_PCSrc),
    .target   (BRANCH_target),
    .advance  (advance),
    .pc_q     (pc_q),
    .pc_d     (pc_d)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    advance    = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // araddr is frozen here; a redirect only arms kill so the reply is dropped
        kill_d = kill_q | BRANCH_PCSrc;
        if (bus.IFU_arready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.IFU_rvalid) begin
          if (kill_q || BRANCH_PCSrc) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = bus.IFU_rdata;
            fault_d = (bus.IFU_rresp != RESP_OKAY);
            state_d = HOLD;
          end
        end else begin
          kill_d = kill_q | BRANCH_PCSrc;
        end
      end
      HOLD: begin
        if (BRANCH_PCSrc) begin
          state_d = REQ;
        end else if (bus.IFU_ready) begin
          advance = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // the request address is captured once, on entry to REQ, from the next PC
    if (state_d == REQ && state_q != REQ) req_addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      req_addr_q <= RESET_PC;
      inst_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.IFU_arvalid = (state_q == REQ);
  assign bus.IFU_araddr  = (state_q == REQ)  ? req_addr_q : '0;
  assign bus.IFU_rready  = (state_q == WAIT);
  assign bus.IFU_valid   = (state_q == HOLD) & ~BRANCH_PCSrc;
  assign bus.IFU_pc      = (state_q == HOLD) ? req_addr_q : '0;
  assign bus.IFU_inst    = (state_q == HOLD) ? inst_q     : '0;
  assign bus.IFU_fault   = (state_q == HOLD) & fault_q;
endmodule

// File: tb/tb_ifu_fetch_redirect_ysyx23060136.sv
// Directed bench: table of reset-to-third-fetch runs plus hand sequences for stall and redirect corners.
module tb_ifu_fetch_redirect_ysyx23060136;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] target = '0;
  logic        ar_en = 1'b1;
  logic        id_rdy = 1'b1;
  int          lat = 1;
  logic [31:0] err_addr = '0;

  int checks = 0;
  int failures = 0;

  ifu_fetch_redirect_ysyx23060136_if bus();

  ifu_fetch_redirect_ysyx23060136 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .BRANCH_PCSrc  (pcsrc),
    .BRANCH_target (target),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // memory: accepts one read, answers after lat cycles, reset together with the DUT
  logic        m_busy, m_rvalid;
  logic [31:0] m_addr, m_rdata;
  logic [1:0]  m_rresp;
  int          m_cnt;
  assign bus.IFU_arready = ar_en;
  assign bus.IFU_rvalid  = m_rvalid;
  assign bus.IFU_rdata   = m_rdata;
  assign bus.IFU_rresp   = m_rresp;
  assign bus.IFU_ready   = id_rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_rvalid <= 1'b0; m_cnt <= 0;
      m_addr <= '0; m_rdata <= '0; m_rresp <= '0;
    end else if (m_rvalid && bus.IFU_rready) begin
      m_rvalid <= 1'b0; m_busy <= 1'b0;
    end else if (m_busy && !m_rvalid) begin
      if (m_cnt <= 1) begin
        m_rvalid <= 1'b1; m_rdata <= inst_of(m_addr);
        m_rresp <= (m_addr == err_addr) ? 2'b10 : 2'b00;
      end else m_cnt <= m_cnt - 1;
    end else if (!m_busy && bus.IFU_arvalid && bus.IFU_arready) begin
      m_addr <= bus.IFU_araddr; m_busy <= 1'b1;
      if (lat <= 1) begin
        m_rvalid <= 1'b1; m_rdata <= inst_of(bus.IFU_araddr);
        m_rresp <= (bus.IFU_araddr == err_addr) ? 2'b10 : 2'b00;
      end else m_cnt <= lat - 1;
    end
  end

  // monitor: logs accepted requests and delivered instructions, checks araddr stability
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic fault; } dlv_t;
  logic [31:0] ar_log[$];
  dlv_t        dlv_log[$];
  logic        ar_stall_prev = 1'b0;
  logic [31:0] ar_prev_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.IFU_arvalid && bus.IFU_arready) ar_log.push_back(bus.IFU_araddr);
      if (bus.IFU_valid && bus.IFU_ready) dlv_log.push_back({bus.IFU_pc, bus.IFU_inst, bus.IFU_fault});
      if (ar_stall_prev) begin
        checks++;
        if (!(bus.IFU_arvalid && bus.IFU_araddr == ar_prev_addr)) begin
          failures++;
          $display("FAIL ar_stable actual arvalid=%0b araddr=%h required arvalid=1 araddr=%h",
                   bus.IFU_arvalid, bus.IFU_araddr, ar_prev_addr);
        end
      end
      ar_stall_prev = bus.IFU_arvalid && !bus.IFU_arready;
      ar_prev_addr  = bus.IFU_araddr;
    end else ar_stall_prev = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pcsrc = 1'b0; ar_en = 1'b1; id_rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_arvalid", 32'(bus.IFU_arvalid), 32'd0);
    chk("rst_rready",  32'(bus.IFU_rready),  32'd0);
    chk("rst_valid",   32'(bus.IFU_valid),   32'd0);
    ar_log.delete(); dlv_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_dlv(input int n, input string nm);
    int t = 0;
    while (dlv_log.size() < n && t < 300) begin @(posedge clk); t++; end
    #1;
    checks++;
    if (dlv_log.size() < n) begin
      failures++;
      $display("FAIL %s timeout delivered=%0d required=%0d", nm, dlv_log.size(), n);
    end
  endtask

  task automatic wait_sig(input int which, input logic [31:0] pcv, input string nm);
    int  t = 0;
    logic hit = 1'b0;
    while (!hit && t < 300) begin
      @(posedge clk); #1; t++;
      case (which)
        0: hit = bus.IFU_valid;
        1: hit = bus.IFU_valid && bus.IFU_pc == pcv;
        2: hit = bus.IFU_rready;
        default: hit = bus.IFU_arvalid;
      endcase
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL %s timeout actual=not_seen required=seen", nm); end
  endtask

  typedef struct {
    int                 lat;
    logic [31:0]        err;
    logic [2:0][31:0]   exp_pc;
    logic [2:0]         exp_fault;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 32'h0,         {32'h8000_0008, 32'h8000_0004, 32'h8000_0000}, 3'b000};
    vecs[1] = '{3, 32'h0,         {32'h8000_0008, 32'h8000_0004, 32'h8000_0000}, 3'b000};
    vecs[2] = '{1, 32'h8000_0004, {32'h8000_0008, 32'h8000_0004, 32'h8000_0000}, 3'b010};
    vecs[3] = '{2, 32'h8000_0008, {32'h8000_0008, 32'h8000_0004, 32'h8000_0000}, 3'b100};

    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat; err_addr = vecs[i].err;
      do_reset();
      chk("idle_arvalid", 32'(bus.IFU_arvalid), 32'd0);
      @(posedge clk); #1;
      chk("first_arvalid", 32'(bus.IFU_arvalid), 32'd1);
      chk("first_araddr",  bus.IFU_araddr, 32'h8000_0000);
      wait_dlv(3, "vec_dlv");
      for (int k = 0; k < 3; k++) begin
        if (dlv_log.size() > k && ar_log.size() > k) begin
          chk("vec_araddr", ar_log[k], vecs[i].exp_pc[k]);
          chk("vec_pc",     dlv_log[k].pc, vecs[i].exp_pc[k]);
          chk("vec_inst",   dlv_log[k].inst, inst_of(vecs[i].exp_pc[k]));
          chk("vec_fault",  32'(dlv_log[k].fault), 32'(vecs[i].exp_fault[k]));
        end
      end
    end

    // ID stall in HOLD
    begin
      logic [31:0] p, ins;
      lat = 1; err_addr = '0;
      do_reset();
      id_rdy = 1'b0;
      wait_sig(0, '0, "stall_valid");
      p = bus.IFU_pc; ins = bus.IFU_inst;
      chk("stall_pc0", p, 32'h8000_0000);
      repeat (5) begin
        @(posedge clk); #1;
        chk("stall_valid",   32'(bus.IFU_valid),   32'd1);
        chk("stall_pc",      bus.IFU_pc,   p);
        chk("stall_inst",    bus.IFU_inst, ins);
        chk("stall_arvalid", 32'(bus.IFU_arvalid), 32'd0);
      end
      id_rdy = 1'b1;
      @(posedge clk); #1;
      chk("stall_next_arvalid", 32'(bus.IFU_arvalid), 32'd1);
      chk("stall_next_araddr",  bus.IFU_araddr, 32'h8000_0004);
      wait_dlv(2, "stall_dlv");
      if (dlv_log.size() >= 2) chk("stall_dlv_pc", dlv_log[1].pc, 32'h8000_0004);
    end

    // redirect in HOLD, same cycle as ID ready
    lat = 1; err_addr = '0;
    do_reset();
    wait_sig(1, 32'h8000_0010, "hold_reach");
    pcsrc = 1'b1; target = 32'h8000_0100;
    #1;
    chk("hold_redir_valid", 32'(bus.IFU_valid), 32'd0);
    @(posedge clk); #1;
    pcsrc = 1'b0;
    chk("hold_redir_arvalid", 32'(bus.IFU_arvalid), 32'd1);
    chk("hold_redir_araddr",  bus.IFU_araddr, 32'h8000_0100);
    wait_dlv(5, "hold_redir_dlv");
    if (dlv_log.size() >= 5) begin
      chk("hold_redir_pc",   dlv_log[4].pc,   32'h8000_0100);
      chk("hold_redir_inst", dlv_log[4].inst, inst_of(32'h8000_0100));
    end

    // redirect in WAIT: latency 4 (no rvalid yet) and latency 1 (rvalid same cycle)
    for (int c = 0; c < 2; c++) begin
      logic [31:0] tg;
      tg  = (c == 0) ? 32'h8000_0200 : 32'h8000_0300;
      lat = (c == 0) ? 4 : 1;
      do_reset();
      wait_sig(2, '0, "wait_reach");
      pcsrc = 1'b1; target = tg;
      @(posedge clk); #1;
      pcsrc = 1'b0;
      wait_dlv(2, "wait_redir_dlv");
      if (dlv_log.size() >= 2 && ar_log.size() >= 2) begin
        chk("wait_redir_araddr", ar_log[1],       tg);
        chk("wait_redir_pc",     dlv_log[0].pc,   tg);
        chk("wait_redir_inst",   dlv_log[0].inst, inst_of(tg));
        chk("wait_redir_pc2",    dlv_log[1].pc,   tg + 32'd4);
      end
    end

    // back-to-back redirects in WAIT: the last target wins
    lat = 4;
    do_reset();
    wait_sig(2, '0, "b2b_reach");
    pcsrc = 1'b1; target = 32'h8000_0500;
    @(posedge clk); #1;
    target = 32'h8000_0600;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    wait_dlv(1, "b2b_dlv");
    if (dlv_log.size() >= 1 && ar_log.size() >= 2) begin
      chk("b2b_araddr", ar_log[1],     32'h8000_0600);
      chk("b2b_pc",     dlv_log[0].pc, 32'h8000_0600);
    end

    // redirect in REQ while arready is held low for 3 cycles
    lat = 2;
    do_reset();
    ar_en = 1'b0;
    wait_sig(3, '0, "req_reach");
    pcsrc = 1'b1; target = 32'h8000_0400;
    chk("req_redir_araddr0", bus.IFU_araddr, 32'h8000_0000);
    @(posedge clk); #1;
    pcsrc = 1'b0;
    repeat (2) begin
      chk("req_redir_araddr", bus.IFU_araddr, 32'h8000_0000);
      @(posedge clk); #1;
    end
    ar_en = 1'b1;
    wait_dlv(1, "req_redir_dlv");
    if (dlv_log.size() >= 1 && ar_log.size() >= 2) begin
      chk("req_redir_ar0", ar_log[0],       32'h8000_0000);
      chk("req_redir_ar1", ar_log[1],       32'h8000_0400);
      chk("req_redir_pc",  dlv_log[0].pc,   32'h8000_0400);
      chk("req_redir_inst", dlv_log[0].inst, inst_of(32'h8000_0400));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
